alu_result_serializer: RTL and testbench

ALU_RESULT_SERIALIZER -- requirements
Module: alu_result_serializer

---
 rtl/alu_result_serializer.sv | 139 +++++++++++++
 tb/tb_alu_result_serializer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_serializer.sv
// alu_result_serializer
// Captures a wide ALU result two cycles after its opcode is issued and streams it
// out as a sequence of WORD_WIDTH words over a valid/ready handshake.
// Optional build macro: ALU_SER_MSB_FIRST_EN
//   undefined -> word 0 is alu_out[WORD_WIDTH-1:0] (least-significant word first)
//   defined   -> word 0 is alu_out[DATA_WIDTH-1 -: WORD_WIDTH] (most-significant word first)
// Results that arrive while a previous result is still streaming are discarded and
// counted in a saturating drop counter, except when they arrive exactly as the
// final word transfers, in which case they are chained with no bubble.

module alu_result_serializer #(
    parameter int DATA_WIDTH = 1024,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  op_valid,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic [7:0]            drop_cnt
);

    localparam int NUM_WORDS = DATA_WIDTH / WORD_WIDTH;
    localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q;
    logic                    opValidS1_q;
    logic                    capValid_q;
    logic [DATA_WIDTH-1:0]   shiftBuf_q;
    logic [DATA_WIDTH-1:0]   shiftBuf_d;
    logic [IDX_W-1:0]        wordIdx_q;
    logic                    outValid_q;
    logic                    outLast_q;
    logic [7:0]              dropCnt_q;
    logic [WORD_WIDTH-1:0]   curWord;
    logic                    transfer;
    logic                    lastTransfer;

    // The current word always sits at the output end of the shift buffer, so
    // advancing to the next word is a single fixed shift with zero fill.
`ifdef ALU_SER_MSB_FIRST_EN
    assign curWord    = shiftBuf_q[DATA_WIDTH-1 -: WORD_WIDTH];
    assign shiftBuf_d = shiftBuf_q << WORD_WIDTH;
`else
    assign curWord    = shiftBuf_q[WORD_WIDTH-1:0];
    assign shiftBuf_d = shiftBuf_q >> WORD_WIDTH;
`endif

    assign transfer     = outValid_q && out_ready;
    assign lastTransfer = transfer && outLast_q;

    assign out_data  = curWord;
    assign out_valid = outValid_q;
    assign out_last  = outLast_q;
    assign busy      = (state_q == SEND);
    assign drop_cnt  = dropCnt_q;

    // Two-stage op_valid delay line aligned with the upstream mux latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opValidS1_q <= 1'b0;
            capValid_q  <= 1'b0;
        end else begin
            opValidS1_q <= op_valid;
            capValid_q  <= opValidS1_q;
        end
    end

    // Serializer FSM: loads a result, walks its words on each handshake and
    // chains straight into the next result when one lands on the final transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shiftBuf_q <= '0;
            wordIdx_q  <= '0;
            outValid_q <= 1'b0;
            outLast_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capValid_q) begin
                        state_q    <= SEND;
                        shiftBuf_q <= alu_out;
                        wordIdx_q  <= '0;
                        outValid_q <= 1'b1;
                        outLast_q  <= (NUM_WORDS == 1);
                    end
                end
                SEND: begin
                    if (lastTransfer) begin
                        if (capValid_q) begin
                            state_q    <= SEND;
                            shiftBuf_q <= alu_out;
                            wordIdx_q  <= '0;
                            outValid_q <= 1'b1;
                            outLast_q  <= (NUM_WORDS == 1);
                        end else begin
                            state_q    <= IDLE;
                            shiftBuf_q <= shiftBuf_d;
                            wordIdx_q  <= '0;
                            outValid_q <= 1'b0;
                            outLast_q  <= 1'b0;
                        end
                    end else if (transfer) begin
                        shiftBuf_q <= shiftBuf_d;
                        wordIdx_q  <= wordIdx_q + IDX_W'(1);
                        outLast_q  <= (wordIdx_q == (LAST_IDX - IDX_W'(1)));
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                    outLast_q  <= 1'b0;
                end
            endcase
        end
    end

    // Count results that arrive while streaming and cannot be chained; saturates at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dropCnt_q <= 8'd0;
        end else if ((state_q == SEND) && capValid_q && !lastTransfer
                     && (dropCnt_q != 8'hFF)) begin
            dropCnt_q <= dropCnt_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer
// Directed bench for alu_result_serializer with 1024-bit results and 32-bit words.
// Expected words are derived from the bench's own stimulus; word order follows
// ALU_SER_MSB_FIRST_EN in the same way as the design build.

module tb_alu_result_serializer;

    localparam int DW = 1024;
    localparam int WW = 32;
    localparam int NW = DW / WW;

    logic          clk;
    logic          rst_n;
    logic          op_valid;
    logic [DW-1:0] alu_out;
    logic [WW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          busy;
    logic [7:0]    drop_cnt;

    int assertCount = 0;
    int failCount   = 0;

    alu_result_serializer #(
        .DATA_WIDTH (DW),
        .WORD_WIDTH (WW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .alu_out   (alu_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls outside the bounded loops.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] makeData(input logic [31:0] base, input logic [31:0] step);
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < NW; i++) r[32*i +: 32] = base + step * 32'(i);
        return r;
    endfunction

    function automatic logic [31:0] expWord(input logic [DW-1:0] d, input int i);
`ifdef ALU_SER_MSB_FIRST_EN
        return d[(DW-1-32*i) -: 32];
`else
        return d[32*i +: 32];
`endif
    endfunction

    // Present op_valid for one cycle with the result already on alu_out.
    task automatic applyStimulus(input logic [DW-1:0] d);
        alu_out  = d;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    // Collect one full result; mode 0 keeps ready high, mode 1 drives ready 1,0,0,...
    task automatic collectResult(input logic [DW-1:0] d, input int mode, input string tag);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < NW && cyc < 400) begin
            out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (out_valid) begin
                checkOutput({tag, "_data"}, out_data, expWord(d, got));
                checkOutput({tag, "_last"}, 32'(out_last), 32'(got == NW-1));
                if (out_ready) got++;
            end else if (got > 0) begin
                checkOutput({tag, "_gap"}, 32'(out_valid), 32'd1);
            end
            tick();
            cyc++;
        end
        if (got < NW) checkOutput({tag, "_timeout"}, 32'(got), 32'(NW));
        out_ready = 1'b1;
        checkOutput({tag, "_endvalid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_endbusy"}, 32'(busy), 32'd0);
    endtask

    task automatic doReset;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    logic [DW-1:0] dataA;
    logic [DW-1:0] dataB;

    initial begin
        rst_n     = 1'b0;
        op_valid  = 1'b0;
        alu_out   = '0;
        out_ready = 1'b1;
        #1;

        // Reset state
        checkOutput("rst_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_last",  32'(out_last),  32'd0);
        checkOutput("rst_busy",  32'(busy),      32'd0);
        checkOutput("rst_data",  out_data,       32'd0);
        checkOutput("rst_drop",  32'(drop_cnt),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single result, ready held high, word i == i
        dataA = makeData(32'd0, 32'd1);
        applyStimulus(dataA);
        checkOutput("t1_c1_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("t1_c2_valid", 32'(out_valid), 32'd0);
        tick();
        for (int i = 0; i < NW; i++) begin
            checkOutput("t1_valid", 32'(out_valid), 32'd1);
            checkOutput("t1_busy",  32'(busy),      32'd1);
            checkOutput("t1_data",  out_data,       expWord(dataA, i));
            checkOutput("t1_last",  32'(out_last),  32'(i == NW-1));
            tick();
        end
        checkOutput("t1_end_valid", 32'(out_valid), 32'd0);
        checkOutput("t1_end_busy",  32'(busy),      32'd0);
        checkOutput("t1_end_last",  32'(out_last),  32'd0);

        // Backpressure with ready pattern 1,0,0
        dataB = makeData(32'hC0DE_0000, 32'h0001_0101);
        applyStimulus(dataB);
        collectResult(dataB, 1, "t2");
        checkOutput("t2_drop", 32'(drop_cnt), 32'd0);

        // Back-to-back: second capture coincides with the word-31 transfer
        dataA = makeData(32'h1000_0000, 32'd7);
        dataB = makeData(32'h2000_0000, 32'd9);
        alu_out   = dataA;
        op_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 1; c <= 2*NW + 3; c++) begin
            tick();
            op_valid = (c == NW);
            if (c == 3) alu_out = dataB;
            if (c >= 3 && c <= 2*NW + 2) begin
                checkOutput("t3_valid", 32'(out_valid), 32'd1);
                checkOutput("t3_data", out_data,
                            (c - 3 < NW) ? expWord(dataA, c - 3) : expWord(dataB, c - 3 - NW));
                checkOutput("t3_last", 32'(out_last), 32'(((c - 3) % NW) == NW-1));
            end else begin
                checkOutput("t3_idle_valid", 32'(out_valid), 32'd0);
            end
        end
        checkOutput("t3_drop", 32'(drop_cnt), 32'd0);

        // Overflow: ready low, 300 captures while streaming
        dataA = makeData(32'hABCD_0000, 32'd3);
        out_ready = 1'b0;
        applyStimulus(dataA);
        tick();
        tick();
        alu_out  = makeData(32'hDEAD_0000, 32'd5);
        op_valid = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        op_valid = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("t4_drop", 32'(drop_cnt), 32'd255);
        checkOutput("t4_busy", 32'(busy),     32'd1);
        checkOutput("t4_held", out_data,      expWord(dataA, 0));
        collectResult(dataA, 0, "t4");
        checkOutput("t4_drop_after", 32'(drop_cnt), 32'd255);

        // Reset mid-result after word 10 transfers
        dataA = makeData(32'h5555_0000, 32'd11);
        out_ready = 1'b1;
        applyStimulus(dataA);
        tick();
        tick();
        for (int i = 0; i <= 10; i++) begin
            checkOutput("t5_data", out_data, expWord(dataA, i));
            if (i == 10) op_valid = 1'b1;
            tick();
        end
        op_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_valid", 32'(out_valid), 32'd0);
        checkOutput("t5_rst_data",  out_data,       32'd0);
        checkOutput("t5_rst_last",  32'(out_last),  32'd0);
        checkOutput("t5_rst_busy",  32'(busy),      32'd0);
        checkOutput("t5_rst_drop",  32'(drop_cnt),  32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t5_quiet_valid", 32'(out_valid), 32'd0);
        end
        checkOutput("t5_quiet_drop", 32'(drop_cnt), 32'd0);
        dataB = makeData(32'h7777_0000, 32'd13);
        applyStimulus(dataB);
        collectResult(dataB, 0, "t5_new");

        // Single set bit in the least-significant position
        dataA = '0;
        dataA[0] = 1'b1;
        applyStimulus(dataA);
        collectResult(dataA, 0, "t6");

        doReset();
        checkOutput("t7_valid", 32'(out_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
